// File: rtl/mouse_position_tracker.sv
// rtl/mouse_position_tracker.sv - PS/2 3-byte packet assembler with clamped fixed-point cursor tracking
module mouse_position_tracker #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int FRAC_BITS      = 12,
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int SPEED_SHIFT    = 0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] x_mouse,
  output logic [31:0] y_mouse,
  output logic [2:0]  buttons,
  output logic        pos_update,
  output logic        sync_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SH = FRAC_BITS + SPEED_SHIFT;
  localparam logic signed [33:0] X_MAX = 34'(SCREEN_W - 1) << FRAC_BITS;
  localparam logic signed [33:0] Y_MAX = 34'(SCREEN_H - 1) << FRAC_BITS;
  localparam logic [31:0] X_INIT = 32'(INIT_X) << FRAC_BITS;
  localparam logic [31:0] Y_INIT = 32'(INIT_Y) << FRAC_BITS;
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

  state_t          state_q, state_d;
  // status byte minus the always-one bit 3: {ovf_y, ovf_x, sign_y, sign_x, btn[2:0]}
  logic [6:0]      stat_q, stat_d;
  logic [7:0]      dx_q, dx_d, dy_q, dy_d;
  logic [31:0]     x_q, x_d, y_q, y_d;
  logic [2:0]      btn_q, btn_d;
  logic            upd_q, upd_d, err_q, err_d;
  logic [CW-1:0]   idle_q, idle_d;

  logic signed [33:0] dx_ext, dy_ext, nx, ny;

  function automatic logic [31:0] clamp(input logic signed [33:0] v,
                                        input logic signed [33:0] vmax);
    if (v < 0)         return 32'd0;
    else if (v > vmax) return vmax[31:0];
    else               return v[31:0];
  endfunction

  assign dx_ext = stat_q[5] ? '0 : {{25{stat_q[3]}}, stat_q[3], dx_q};
  assign dy_ext = stat_q[6] ? '0 : {{25{stat_q[4]}}, stat_q[4], dy_q};
  // PS/2 +Y points up while screen +Y points down, hence the subtraction
  assign nx = $signed({2'b00, x_q}) + (dx_ext <<< SH);
  assign ny = $signed({2'b00, y_q}) - (dy_ext <<< SH);

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    idle_d  = idle_q;
    case (state_q)
      WAIT_B0: begin
        idle_d = '0;
        if (rx_valid) begin
          if (rx_data[3]) begin
            stat_d  = {rx_data[7:4], rx_data[2:0]};
            state_d = WAIT_B1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (rx_valid) begin
          idle_d = '0;
          if (state_q == WAIT_B1) begin
            dx_d    = rx_data;
            state_d = WAIT_B2;
          end else begin
            dy_d    = rx_data;
            state_d = UPDATE;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = WAIT_B0;
          err_d   = 1'b1;
          idle_d  = '0;
        end else if (idle_q != '1) begin
          idle_d = idle_q + 1'b1;
        end
      end
      UPDATE: begin
        x_d     = clamp(nx, X_MAX);
        y_d     = clamp(ny, Y_MAX);
        btn_d   = stat_q[2:0];
        upd_d   = 1'b1;
        err_d   = rx_valid;
        idle_d  = '0;
        state_d = WAIT_B0;
      end
      default: state_d = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_B0;
      stat_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
      btn_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
    end
  end

  assign x_mouse    = x_q;
  assign y_mouse    = y_q;
  assign buttons    = btn_q;
  assign pos_update = upd_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb/tb_mouse_position_tracker.sv - table, corner-case and randomized checks for mouse_position_tracker
module tb_mouse_position_tracker;

  localparam int T  = 100;
  localparam int FB = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] x_mouse, y_mouse;
  logic [2:0]  buttons;
  logic        pos_update, sync_err;

  int total = 0;
  int bad   = 0;
  int mx, my;
  logic [2:0] mb;

  mouse_position_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .x_mouse(x_mouse), .y_mouse(y_mouse), .buttons(buttons),
    .pos_update(pos_update), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_first;
    logic [7:0] b0, b1, b2;
    int         ex, ey;
    logic [2:0] eb;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mx = 320; my = 240; mb = 3'b000;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int gap);
    drive_byte(b0, gap);
    drive_byte(b1, gap);
    drive_byte(b2, 0);
  endtask

  // called in the UPDATE cycle; returns in the cycle where the pulse is expected
  task automatic check_update(input string tag, input int ex, input int ey, input logic [2:0] eb);
    chk({tag, ".upd_early"}, 32'(pos_update), 32'd0);
    @(negedge clk);
    chk({tag, ".upd"}, 32'(pos_update), 32'd1);
    chk({tag, ".x"}, x_mouse, 32'(ex) << FB);
    chk({tag, ".y"}, y_mouse, 32'(ey) << FB);
    chk({tag, ".btn"}, 32'(buttons), 32'(eb));
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // reference: apply one PS/2 packet to the whole-pixel cursor position
  function automatic void model_packet(input logic [7:0] st, input logic [7:0] bx, input logic [7:0] by);
    int dx, dy;
    dx = st[4] ? int'(bx) - 256 : int'(bx);
    dy = st[5] ? int'(by) - 256 : int'(by);
    if (st[6]) dx = 0;
    if (st[7]) dy = 0;
    mx = clampi(mx + dx, 639);
    my = clampi(my - dy, 479);
    mb = st[2:0];
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 8'h08, 8'h05, 8'h03, 325, 237, 3'b000};
    vecs[1]  = '{1'b1, 8'h18, 8'hF6, 8'h00, 310, 240, 3'b000};
    vecs[2]  = '{1'b0, 8'h28, 8'h00, 8'hFB, 310, 245, 3'b000};
    vecs[3]  = '{1'b1, 8'h08, 8'h7F, 8'h00, 447, 240, 3'b000};
    vecs[4]  = '{1'b0, 8'h08, 8'h7F, 8'h00, 574, 240, 3'b000};
    vecs[5]  = '{1'b0, 8'h08, 8'h38, 8'h00, 630, 240, 3'b000};
    vecs[6]  = '{1'b0, 8'h08, 8'h7F, 8'h00, 639, 240, 3'b000};
    vecs[7]  = '{1'b0, 8'h18, 8'h80, 8'h00, 511, 240, 3'b000};
    vecs[8]  = '{1'b0, 8'h18, 8'h80, 8'h00, 383, 240, 3'b000};
    vecs[9]  = '{1'b0, 8'h18, 8'h80, 8'h00, 255, 240, 3'b000};
    vecs[10] = '{1'b0, 8'h18, 8'h80, 8'h00, 127, 240, 3'b000};
    vecs[11] = '{1'b0, 8'h18, 8'h86, 8'h00, 5,   240, 3'b000};
    vecs[12] = '{1'b0, 8'h18, 8'h80, 8'h00, 0,   240, 3'b000};
    vecs[13] = '{1'b0, 8'h0F, 8'h00, 8'h00, 0,   240, 3'b111};
    vecs[14] = '{1'b0, 8'h28, 8'h00, 8'h80, 0,   368, 3'b000};
    vecs[15] = '{1'b0, 8'h28, 8'h00, 8'h80, 0,   479, 3'b000};
    vecs[16] = '{1'b0, 8'h08, 8'h00, 8'h7F, 0,   352, 3'b000};
    vecs[17] = '{1'b0, 8'h08, 8'h00, 8'h7F, 0,   225, 3'b000};
    vecs[18] = '{1'b0, 8'h08, 8'h00, 8'h7F, 0,   98,  3'b000};
    vecs[19] = '{1'b0, 8'h08, 8'h00, 8'h7F, 0,   0,   3'b000};
    vecs[20] = '{1'b1, 8'h4A, 8'hFF, 8'h02, 320, 238, 3'b010};
    vecs[21] = '{1'b0, 8'h88, 8'h03, 8'h10, 323, 238, 3'b000};
    vecs[22] = '{1'b0, 8'hC9, 8'h55, 8'h55, 323, 238, 3'b001};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.x", x_mouse, 32'd320 << FB);
    chk("reset.y", y_mouse, 32'd240 << FB);
    chk("reset.btn", 32'(buttons), 32'd0);
    chk("reset.upd", 32'(pos_update), 32'd0);
    chk("reset.err", 32'(sync_err), 32'd0);

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].rst_first) do_reset();
      send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2, 0);
      check_update($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].eb);
      @(negedge clk);
      chk($sformatf("vec%0d.upd_fall", i), 32'(pos_update), 32'd0);
      chk($sformatf("vec%0d.err", i), 32'(sync_err), 32'd0);
    end

    // resync: a byte without bit 3 is dropped in WAIT_B0
    do_reset();
    drive_byte(8'h00, 0);
    chk("resync.err", 32'(sync_err), 32'd1);
    drive_byte(8'h08, 0);
    chk("resync.err_fall", 32'(sync_err), 32'd0);
    drive_byte(8'h01, 0);
    drive_byte(8'h01, 0);
    check_update("resync", 321, 239, 3'b000);

    // timeout inside a packet, then a clean packet
    do_reset();
    drive_byte(8'h08, 0);
    drive_byte(8'h05, 0);
    for (int k = 1; k < T; k++) begin
      if (sync_err !== 1'b0) begin
        chk("timeout.early_err", 32'(sync_err), 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("timeout.err", 32'(sync_err), 32'd1);
    @(negedge clk);
    chk("timeout.err_fall", 32'(sync_err), 32'd0);
    chk("timeout.x_hold", x_mouse, 32'd320 << FB);
    send_packet(8'h09, 8'h02, 8'h00, 0);
    check_update("timeout", 322, 240, 3'b001);

    // a byte arriving exactly at expiry is accepted
    do_reset();
    drive_byte(8'h08, T - 1);
    drive_byte(8'h05, 0);
    chk("expiry.err", 32'(sync_err), 32'd0);
    drive_byte(8'h00, 0);
    check_update("expiry", 325, 240, 3'b000);

    // byte during UPDATE is dropped but the update still commits
    do_reset();
    send_packet(8'h08, 8'h01, 8'h01, 0);
    drive_byte(8'h08, 0);
    chk("inupd.err", 32'(sync_err), 32'd1);
    chk("inupd.upd", 32'(pos_update), 32'd1);
    chk("inupd.x", x_mouse, 32'd321 << FB);
    send_packet(8'h08, 8'h02, 8'h00, 0);
    check_update("inupd.next", 323, 239, 3'b000);

    // reset asserted in the UPDATE cycle suppresses the update
    send_packet(8'h0C, 8'h20, 8'h20, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstupd.upd", 32'(pos_update), 32'd0);
    chk("rstupd.x", x_mouse, 32'd320 << FB);
    chk("rstupd.y", y_mouse, 32'd240 << FB);
    chk("rstupd.btn", 32'(buttons), 32'd0);
    @(negedge clk);
    chk("rstupd.upd2", 32'(pos_update), 32'd0);

    // randomized packets with inter-byte gaps and junk bytes against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [7:0] st, bx, by;
      int gap;
      if ($urandom_range(0, 7) == 0) begin
        drive_byte(8'($urandom) & 8'hF7, 0);
        chk($sformatf("rnd%0d.junk_err", n), 32'(sync_err), 32'd1);
      end
      st  = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 3) != 0) st[7:6] = 2'b00;
      bx  = 8'($urandom);
      by  = 8'($urandom);
      gap = $urandom_range(0, 10);
      send_packet(st, bx, by, gap);
      model_packet(st, bx, by);
      check_update($sformatf("rnd%0d", n), mx, my, mb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
